// File: rtl/pc_sel_pkg.sv
// Shared types and default vectors for the next-PC generator.
// Source encodings double as priorities: a larger value always wins.
package pc_sel_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ = 3'd0,
        SRC_J   = 3'd1,
        SRC_JR  = 3'd2,
        SRC_BR  = 3'd3,
        SRC_IRQ = 3'd4,
        SRC_EXC = 3'd5
    } src_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP    = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR     = 32'h8000_0008;

    function automatic logic is_trap(input src_e s);
        return (s == SRC_EXC) || (s == SRC_IRQ);
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational priority encoder: picks the winning redirect source and target,
// plus the target that would win if traps were ignored (used as the irq EPC).
module pc_target_sel
    import pc_sel_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter int                 JT_W  = 26,
    parameter logic [WIDTH-1:0]   ILLOP = DEF_ILLOP,
    parameter logic [WIDTH-1:0]   XADR  = DEF_XADR
) (
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jr_valid,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             j_valid,
    input  logic [JT_W-1:0]  j_index,
    input  logic             exc_req,
    input  logic             irq_req,
    output src_e             src,
    output logic [WIDTH-1:0] tgt,
    output src_e             nt_src,
    output logic [WIDTH-1:0] nt_tgt
);

    always_comb begin
        nt_src = SRC_SEQ;
        nt_tgt = pc_plus4;
        if (br_valid && br_taken) begin
            nt_src = SRC_BR;
            nt_tgt = br_target;
        end else if (jr_valid) begin
            nt_src = SRC_JR;
            nt_tgt = jr_target;
        end else if (j_valid) begin
            nt_src = SRC_J;
            nt_tgt = {pc_plus4[WIDTH-1:JT_W+2], j_index, 2'b00};
        end

        src = nt_src;
        tgt = nt_tgt;
        if (exc_req) begin
            src = SRC_EXC;
            tgt = XADR;
        end else if (irq_req) begin
            src = SRC_IRQ;
            tgt = ILLOP;
        end
    end

endmodule

// File: rtl/pc_sel_unit.sv
// Next-PC generator: owns the PC, holds redirects across stalls, latches
// interrupts until they can be taken and drives the EPC write and IF/ID flush.
module pc_sel_unit
    import pc_sel_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               JT_W     = 26,
    parameter logic [WIDTH-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WIDTH-1:0] ILLOP    = DEF_ILLOP,
    parameter logic [WIDTH-1:0] XADR     = DEF_XADR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jr_valid,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             j_valid,
    input  logic [JT_W-1:0]  j_index,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_epc,
    input  logic             irq,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             epc_we,
    output logic             flush
);

    state_e           state;
    src_e             pend_kind;
    logic [WIDTH-1:0] pend_tgt;
    logic [WIDTH-1:0] pend_epc;
    logic             irq_pend;

    src_e             src;
    src_e             nt_src;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] nt_tgt;
    logic             irq_req;
    logic [WIDTH-1:0] run_epc;
    logic [WIDTH-1:0] held_epc;
    logic             upgrade;

    assign pc_plus4 = pc + {{(WIDTH-3){1'b0}}, 3'd4};

    // Interrupts are masked in kernel mode and yield to a same-cycle exception.
    assign irq_req = (irq_pend | irq) & ~pc[WIDTH-1] & ~exc_req;

    pc_target_sel #(
        .WIDTH (WIDTH),
        .JT_W  (JT_W),
        .ILLOP (ILLOP),
        .XADR  (XADR)
    ) u_target_sel (
        .pc_plus4  (pc_plus4),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jr_valid  (jr_valid),
        .jr_target (jr_target),
        .j_valid   (j_valid),
        .j_index   (j_index),
        .exc_req   (exc_req),
        .irq_req   (irq_req),
        .src       (src),
        .tgt       (tgt),
        .nt_src    (nt_src),
        .nt_tgt    (nt_tgt)
    );

    assign run_epc = (src == SRC_EXC) ? exc_epc : nt_tgt;
    assign upgrade = (src > pend_kind);

    // An irq upgrading a held branch/jump returns to whichever non-trap target ranks higher.
    always_comb begin
        held_epc = pend_tgt;
        if (src == SRC_EXC)
            held_epc = exc_epc;
        else if (nt_src > pend_kind)
            held_epc = nt_tgt;
    end

    always_comb begin
        flush  = 1'b0;
        epc_we = 1'b0;
        epc    = '0;
        if (!reset && !stall) begin
            if (state == ST_RUN) begin
                flush = (src != SRC_SEQ);
                if (is_trap(src)) begin
                    epc_we = 1'b1;
                    epc    = run_epc;
                end
            end else begin
                flush = 1'b1;
                if (is_trap(pend_kind)) begin
                    epc_we = 1'b1;
                    epc    = pend_epc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            state     <= ST_RUN;
            irq_pend  <= 1'b0;
            pend_tgt  <= '0;
            pend_epc  <= '0;
            pend_kind <= SRC_SEQ;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        pc       <= tgt;
                        irq_pend <= (irq_pend | irq) & (src != SRC_IRQ);
                    end else begin
                        irq_pend <= irq_pend | irq;
                        if (src != SRC_SEQ) begin
                            pend_tgt  <= tgt;
                            pend_kind <= src;
                            pend_epc  <= run_epc;
                            state     <= ST_HELD;
                        end
                    end
                end
                ST_HELD: begin
                    if (!stall) begin
                        pc       <= pend_tgt;
                        state    <= ST_RUN;
                        irq_pend <= (irq_pend | irq) & (pend_kind != SRC_IRQ);
                    end else begin
                        irq_pend <= irq_pend | irq;
                        if (upgrade) begin
                            pend_tgt  <= tgt;
                            pend_kind <= src;
                            pend_epc  <= held_epc;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sel_unit.sv
// Directed and randomized bench for pc_sel_unit with an expected-PC queue.
module tb_pc_sel_unit;
    import pc_sel_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall, br_valid, br_taken, jr_valid, j_valid, exc_req, irq;
    logic [31:0] br_target, jr_target, exc_epc;
    logic [25:0] j_index;
    logic [31:0] pc, pc_plus4, epc;
    logic        epc_we, flush;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pc_sel_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jr_valid  (jr_valid),
        .jr_target (jr_target),
        .j_valid   (j_valid),
        .j_index   (j_index),
        .exc_req   (exc_req),
        .exc_epc   (exc_epc),
        .irq       (irq),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .epc       (epc),
        .epc_we    (epc_we),
        .flush     (flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; br_valid = 0; br_taken = 0; br_target = '0;
        jr_valid = 0; jr_target = '0; j_valid = 0; j_index = '0;
        exc_req = 0; exc_epc = '0; irq = 0;
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic step(input logic [31:0] e_pc, input logic e_flush,
                        input logic e_we, input logic [31:0] e_epc);
        logic [31:0] want;
        #2;
        check_eq("flush", {31'd0, flush}, {31'd0, e_flush});
        check_eq("epc_we", {31'd0, epc_we}, {31'd0, e_we});
        check_eq("epc", epc, e_epc);
        exp_q.push_back(e_pc);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check_eq("pc", pc, want);
        check_eq("pc_plus4", pc_plus4, want + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        clear_inputs();
        @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 32'h8000_0000);
        check_eq("rst_state", 32'(dut.state), 32'(ST_RUN));
        check_eq("rst_irq_pend", {31'd0, dut.irq_pend}, 32'd0);
        check_eq("rst_pend_tgt", dut.pend_tgt, 32'd0);
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        check_eq("rst_epc_we", {31'd0, epc_we}, 32'd0);
        check_eq("rst_epc", epc, 32'd0);
        reset = 0;

        // Sequential fetch
        step(32'h8000_0004, 0, 0, 0);
        step(32'h8000_0008, 0, 0, 0);
        step(32'h8000_000C, 0, 0, 0);

        // Branch beats jump; not-taken branch falls through
        jr_valid = 1; jr_target = 32'h100;
        step(32'h100, 1, 0, 0);
        clear_inputs();
        br_valid = 1; br_taken = 1; br_target = 32'h200; j_valid = 1; j_index = 26'h3;
        step(32'h200, 1, 0, 0);
        clear_inputs();
        jr_valid = 1; jr_target = 32'h100;
        step(32'h100, 1, 0, 0);
        clear_inputs();
        br_valid = 1; br_taken = 0; br_target = 32'h200;
        step(32'h104, 0, 0, 0);
        clear_inputs();

        // Jump under a 3-cycle stall
        stall = 1; j_valid = 1; j_index = 26'h40;
        step(32'h104, 0, 0, 0);
        check_eq("held_j", 32'(dut.state), 32'(ST_HELD));
        j_valid = 0;
        step(32'h104, 0, 0, 0);
        step(32'h104, 0, 0, 0);
        stall = 0;
        step(32'h100, 1, 0, 0);
        check_eq("run_after_j", 32'(dut.state), 32'(ST_RUN));
        step(32'h104, 0, 0, 0);

        // Held jump upgraded by branch; lower-priority jr and release-cycle jr ignored
        stall = 1; j_valid = 1; j_index = 26'h40;
        step(32'h104, 0, 0, 0);
        j_valid = 0; br_valid = 1; br_taken = 1; br_target = 32'h300;
        step(32'h104, 0, 0, 0);
        clear_inputs();
        stall = 1; jr_valid = 1; jr_target = 32'h400;
        step(32'h104, 0, 0, 0);
        stall = 0;
        step(32'h300, 1, 0, 0);
        clear_inputs();
        step(32'h304, 0, 0, 0);

        // Interrupt together with a taken branch in user mode
        jr_valid = 1; jr_target = 32'h10;
        step(32'h10, 1, 0, 0);
        clear_inputs();
        irq = 1; br_valid = 1; br_taken = 1; br_target = 32'h80;
        step(32'h8000_0004, 1, 1, 32'h80);
        check_eq("irq_pend_clr", {31'd0, dut.irq_pend}, 32'd0);
        clear_inputs();

        // Kernel-mode irq stays pending; exception wins; irq taken after return to user
        irq = 1;
        step(32'h8000_0008, 0, 0, 0);
        check_eq("irq_pend_set", {31'd0, dut.irq_pend}, 32'd1);
        clear_inputs();
        exc_req = 1; exc_epc = 32'h24;
        step(32'h8000_0008, 1, 1, 32'h24);
        check_eq("irq_pend_exc", {31'd0, dut.irq_pend}, 32'd1);
        clear_inputs();
        jr_valid = 1; jr_target = 32'h28;
        step(32'h28, 1, 0, 0);
        clear_inputs();
        step(32'h8000_0004, 1, 1, 32'h2C);
        check_eq("irq_pend_taken", {31'd0, dut.irq_pend}, 32'd0);

        // Interrupt held across a stall keeps the jr target as its return address
        jr_valid = 1; jr_target = 32'h40;
        step(32'h40, 1, 0, 0);
        clear_inputs();
        stall = 1; irq = 1; jr_valid = 1; jr_target = 32'h60;
        step(32'h40, 0, 0, 0);
        check_eq("held_irq", 32'(dut.state), 32'(ST_HELD));
        clear_inputs();
        step(32'h8000_0004, 1, 1, 32'h60);
        check_eq("irq_pend_held", {31'd0, dut.irq_pend}, 32'd0);

        // Asynchronous reset in HELD discards the pending redirect
        stall = 1; jr_valid = 1; jr_target = 32'h500;
        step(32'h8000_0004, 0, 0, 0);
        check_eq("held_pre_rst", 32'(dut.state), 32'(ST_HELD));
        clear_inputs();
        reset = 1;
        #1;
        check_eq("async_rst_pc", pc, 32'h8000_0000);
        check_eq("async_rst_state", 32'(dut.state), 32'(ST_RUN));
        check_eq("async_rst_flush", {31'd0, flush}, 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        step(32'h8000_0004, 0, 0, 0);

        // PC wraps modulo 2^32
        jr_valid = 1; jr_target = 32'hFFFF_FFFC;
        step(32'hFFFF_FFFC, 1, 0, 0);
        clear_inputs();
        step(32'h0, 0, 0, 0);

        // Random register jumps
        for (int i = 0; i < 6; i++) begin
            r = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
            jr_valid = 1; jr_target = r;
            step(r, 1, 0, 0);
        end
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
